spi_slave_ctrl: RTL and testbench
=================================

# spi_slave_ctrl

SPI slave front end that deserialises MOSI frames into the 10-bit command/data word consumed by the single-port RAM, and serialises read data back onto MISO. It sits between the SPI pins and the RAM's `din`/`rx_valid`/`dout`/`tx_valid` interface. It also tracks whether a read address has been loaded, so it can choose between the read-address and read-data phases.

## Interface
- `ADDR_SIZE`, 8: RAM address/data width. The word width is `ADDR_SIZE+2`.
- `clk` in 1: SPI serial clock; all logic is posedge.
- `rst_n` in 1: reset, synchronous, active-low. Clock is `clk`.
- `SS_n` in 1: slave select, active-low; frames a transaction.
- `MOSI` in 1: serial input, MSB first.
- `MISO` out 1: serial output, MSB first.
- `rx_data` out `ADDR_SIZE+2`: assembled word to RAM `din`; bits [9:8] are the command.
- `rx_valid` out 1: one-cycle strobe; `rx_data` is valid.
- `tx_data` in `ADDR_SIZE`: RAM read data (`dout`).
- `tx_valid` in 1: RAM read data valid.

## Operation
- States: `IDLE`, `CHK_CMD`, `WRITE`, `READ_ADD`, `READ_DATA`.
- Internal flag `rd_addr_seen` selects the read phase.
- `IDLE`: stays while `SS_n`=1. When `SS_n`=0 is sampled, the next state is `CHK_CMD`.
- `CHK_CMD`: samples the select bit on `MOSI`.
  - 0 → `WRITE`.
  - 1 and `rd_addr_seen`=0 → `READ_ADD`.
  - 1 and `rd_addr_seen`=1 → `READ_DATA`.
- `WRITE`, `READ_ADD`, `READ_DATA`: shift in exactly 10 bits, MSB first, into a shift register.
  - On the 10th bit, `rx_data` ← the full word and `rx_valid` pulses for 1 cycle.
  - `rx_data` holds until the next completed frame.
- Command bits are forwarded unmodified. The controller does not check that `din[9:8]` matches the state; the RAM decodes them.
- `READ_ADD` completion sets `rd_addr_seen`=1.
- `READ_DATA` completion clears `rd_addr_seen`=0, then waits for `tx_valid`=1.
  - The controller captures `tx_data` on the first `tx_valid`=1 cycle after its own `rx_valid`.
  - It then drives 8 bits on `MISO`, MSB first, one per cycle.
  - After the last bit, `MISO`=0.
  - `tx_valid` is ignored outside this wait window, because RAM `tx_valid` may stay high.
- After a frame completes with `SS_n` still 0, the block stays in the state. Further MOSI bits are ignored and there is no second `rx_valid`.
- `SS_n`=1 sampled in any non-IDLE state forces `IDLE` on the next edge:
  - the bit counter clears and `MISO`=0;
  - an incomplete frame produces no `rx_valid`;
  - `rd_addr_seen` is unchanged.
- Reset values: state `IDLE`, `MISO`=0, `rx_valid`=0, `rx_data`=0, `rd_addr_seen`=0, counters 0. Reset mid-frame aborts with no strobe.

## Timing
- Let e0 be the edge that first samples `SS_n`=0.
  - e1 samples the select bit.
  - e2 to e11 sample word bits 9 to 0.
  - `rx_valid` is high between e11 and e12.
- Read data, given the RAM asserts `tx_valid` at e12:
  - capture at e13, with `MISO`=`tx_data[7]` from e13;
  - bits 6 to 0 at e14 to e20;
  - `MISO`=0 from e21.
- If `tx_valid` arrives later, the whole MISO sequence shifts by the same delay. The wait is unbounded while `SS_n`=0.
- The master keeps `SS_n`=0 for at least 12 edges (write/read-address) or 21 edges plus the RAM delay (read-data).

## Structure
- Package `spi_pkg`:
  - state enum;
  - command encodings: `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11;
  - `WORD_W`=`ADDR_SIZE+2`.
- One sub-module, `spi_shift_reg`: a parameterised serial-in/parallel-out plus parallel-in/serial-out shifter with bit counter. The FSM stays in the top module.

## Test plan
- Write address: `SS_n` low, MOSI=0 then 10'b00_0011_1010 → `rx_data`=10'h03A, one-cycle `rx_valid` between e11 and e12, state `WRITE` until `SS_n` high.
- Write data: MOSI=0 then 10'b01_1010_0101 → `rx_data`=10'h1A5, single `rx_valid`.
- Read address then read data:
  - MOSI=1, 10'h23C → `rx_data`=10'h23C, `rd_addr_seen`=1.
  - Next frame: MOSI=1, 10'h300, with the RAM model returning 8'hA5 at e12 → MISO 1,0,1,0,0,1,0,1 on e13 to e20, then `rd_addr_seen`=0.
- Abort: `SS_n` high after 5 word bits → no `rx_valid`, `IDLE` next edge. The next full frame decodes correctly.
- Late/sticky `tx_valid`: hold `tx_valid`=1 before the read-data frame → no MISO output until after the controller's `rx_valid`. A `tx_valid` delay of 3 cycles shifts MISO by 3.
- Reset mid-read while shifting MISO → `MISO`=0, `IDLE`, `rd_addr_seen`=0, `rx_valid`=0 on the next edge.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: controller states, SPI command encodings and word width shared by the SPI slave files
package spi_pkg;
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;
  localparam int ADDR_SIZE_DEF = 8;
  localparam int WORD_W = ADDR_SIZE_DEF + 2;
endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: serial-in word shifter with bit counter (i_shift/i_sin -> o_done/o_word) and parallel-in byte shifter (i_load/i_pdin -> registered o_sout), cleared by rst_n low or i_clr
module spi_shift_reg #(
  parameter int RX_W = 10,
  parameter int TX_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_shift,
  input  logic            i_sin,
  input  logic            i_load,
  input  logic [TX_W-1:0] i_pdin,
  output logic            o_done,
  output logic [RX_W-1:0] o_word,
  output logic            o_sout
);
  localparam int CW = $clog2(RX_W);
  logic [RX_W-2:0] r_rx;
  logic [CW-1:0]   r_cnt;
  logic [TX_W-1:0] r_tx;
  assign o_done = i_shift && r_cnt == CW'(RX_W - 1);
  assign o_word = {r_rx, i_sin};
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_rx   <= '0;
      r_cnt  <= '0;
      r_tx   <= '0;
      o_sout <= 1'b0;
    end else begin
      if (i_shift) begin
        r_rx  <= o_word[RX_W-2:0];
        r_cnt <= o_done ? '0 : r_cnt + 1'b1;
      end
      o_sout <= i_load ? i_pdin[TX_W-1] : r_tx[TX_W-1];
      r_tx   <= i_load ? {i_pdin[TX_W-2:0], 1'b0} : {r_tx[TX_W-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave FSM; SS_n/MOSI frames -> rx_data/rx_valid to RAM, RAM tx_data/tx_valid -> MISO, sync active-low rst_n
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);
  state_t               r_state;
  logic                 r_rd_addr_seen;
  logic                 r_done;
  logic                 r_wait;
  logic                 r_rx_valid;
  logic [ADDR_SIZE+1:0] r_rx_data;
  logic                 w_shift;
  logic                 w_load;
  logic                 w_done;
  logic [ADDR_SIZE+1:0] w_word;
  assign w_shift  = !SS_n && !r_done && (r_state == WRITE || r_state == READ_ADD || r_state == READ_DATA);
  // tx_valid only counts once our own rx_valid strobe has dropped, since the RAM may hold it high
  assign w_load   = !SS_n && r_wait && !r_rx_valid && tx_valid;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  spi_shift_reg #(.RX_W(ADDR_SIZE + 2), .TX_W(ADDR_SIZE)) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (SS_n),
    .i_shift (w_shift),
    .i_sin   (MOSI),
    .i_load  (w_load),
    .i_pdin  (tx_data),
    .o_done  (w_done),
    .o_word  (w_word),
    .o_sout  (MISO)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_rd_addr_seen <= 1'b0;
      r_done         <= 1'b0;
      r_wait         <= 1'b0;
      r_rx_valid     <= 1'b0;
      r_rx_data      <= '0;
    end else begin
      r_rx_valid <= w_done;
      if (w_done) r_rx_data <= w_word;
      if (SS_n) begin
        r_state <= IDLE;
        r_done  <= 1'b0;
        r_wait  <= 1'b0;
      end else begin
        case (r_state)
          IDLE:     r_state <= CHK_CMD;
          CHK_CMD:  r_state <= !MOSI ? WRITE : r_rd_addr_seen ? READ_DATA : READ_ADD;
          READ_ADD: if (w_done) begin
            r_done         <= 1'b1;
            r_rd_addr_seen <= 1'b1;
          end
          READ_DATA: if (w_done) begin
            r_done         <= 1'b1;
            r_rd_addr_seen <= 1'b0;
            r_wait         <= 1'b1;
          end else if (w_load) begin
            r_wait <= 1'b0;
          end
          default:  if (w_done) r_done <= 1'b1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: randomized SPI frames checked by a scoreboard of expected rx words and MISO bits
module tb_spi_slave_ctrl;
  import spi_pkg::*;
  logic       clk = 0, rst_n = 0, SS_n = 1, MOSI = 0, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic       MISO, rx_valid;
  logic [9:0] rx_data;
  int checks = 0, errors = 0, cyc = 0;
  bit m_seen = 0;
  typedef struct {int c; logic [9:0] w;} rx_exp_t;
  rx_exp_t rxq[$];
  bit exp_miso[int];
  spi_slave_ctrl #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  always @(negedge clk) begin
    bit em;
    em = exp_miso.exists(cyc) ? exp_miso[cyc] : 1'b0;
    checks++;
    if (MISO !== em) begin
      errors++;
      $display("FAIL miso at cycle %0d: got %b expected %b", cyc, MISO, em);
    end
    if (rxq.size() > 0 && rxq[0].c < cyc) begin
      checks++;
      errors++;
      $display("FAIL rx_valid missing at cycle %0d: got none expected word %h", rxq[0].c, rxq[0].w);
      void'(rxq.pop_front());
    end
    if (rx_valid !== 1'b0) begin
      if (rxq.size() == 0 || rxq[0].c != cyc) begin
        checks++;
        errors++;
        $display("FAIL rx_valid unexpected at cycle %0d: got %b with data %h expected 0", cyc, rx_valid, rx_data);
      end else begin
        chk("rx_data", int'(rx_data), int'(rxq[0].w));
        void'(rxq.pop_front());
      end
    end
  end
  task automatic frame(input bit sel, input logic [9:0] w, input int dly, input bit sticky,
                       input int abort_at, input int rst_at, input logic [7:0] d);
    int c0, cap;
    bit rd;
    state_t st;
    rd = sel && m_seen;
    st = !sel ? WRITE : m_seen ? READ_DATA : READ_ADD;
    tx_data = d;
    tx_valid = sticky;
    SS_n = 0;
    MOSI = 1'($urandom);
    c0 = cyc + 1;
    tick();
    MOSI = sel;
    tick();
    for (int i = 9; i >= 0; i--) begin
      if (abort_at == 9 - i) begin
        SS_n = 1;
        tx_valid = 0;
        tick();
        chk("abort_state", int'(dut.r_state), int'(IDLE));
        chk("abort_seen", int'(dut.r_rd_addr_seen), int'(m_seen));
        return;
      end
      MOSI = w[i];
      if (i == 0) rxq.push_back('{c0 + 11, w});
      tick();
    end
    if (sel) m_seen = !m_seen;
    chk("frame_state", int'(dut.r_state), int'(st));
    chk("rd_addr_seen", int'(dut.r_rd_addr_seen), int'(m_seen));
    if (rd) begin
      if (sticky) cap = c0 + 13;
      else begin
        repeat (dly + 1) begin
          MOSI = 1'($urandom);
          tick();
        end
        tx_valid = 1;
        cap = cyc + 1;
      end
      for (int b = 0; b < 8; b++) exp_miso[cap + b] = d[7 - b];
      while (cyc < cap + 8) begin
        if (rst_at >= 0 && cyc == cap + rst_at) begin
          rst_n = 0;
          for (int c = cyc + 1; c < cap + 8; c++) exp_miso.delete(c);
          tick();
          chk("rst_state", int'(dut.r_state), int'(IDLE));
          chk("rst_seen", int'(dut.r_rd_addr_seen), 0);
          chk("rst_rx_data", int'(rx_data), 0);
          rst_n = 1;
          SS_n = 1;
          tx_valid = 0;
          m_seen = 0;
          tick();
          return;
        end
        MOSI = 1'($urandom);
        tick();
      end
      repeat ($urandom_range(0, 2)) begin
        MOSI = 1'($urandom);
        tick();
      end
    end else begin
      repeat ($urandom_range(1, 3)) begin
        MOSI = 1'($urandom);
        tick();
      end
    end
    SS_n = 1;
    tx_valid = 0;
    tick();
    chk("end_state", int'(dut.r_state), int'(IDLE));
    repeat ($urandom_range(0, 2)) tick();
  endtask
  initial begin
    repeat (3) tick();
    chk("reset_state", int'(dut.r_state), int'(IDLE));
    chk("reset_seen", int'(dut.r_rd_addr_seen), 0);
    chk("reset_rx_data", int'(rx_data), 0);
    rst_n = 1;
    tick();
    frame(0, 10'h03A, 0, 0, -1, -1, 8'h00);
    frame(0, 10'h1A5, 0, 0, -1, -1, 8'h00);
    frame(1, 10'h23C, 0, 0, -1, -1, 8'h00);
    frame(1, 10'h300, 0, 0, -1, -1, 8'hA5);
    frame(0, 10'h155, 0, 0, 5, -1, 8'h00);
    frame(0, {CMD_WR_DATA, 8'hC3}, 0, 0, -1, -1, 8'h00);
    frame(1, {CMD_RD_ADDR, 8'hAA}, 0, 1, -1, -1, 8'h3C);
    frame(1, {CMD_RD_DATA, 8'hF0}, 0, 1, -1, -1, 8'h96);
    frame(1, {CMD_RD_ADDR, 8'h11}, 0, 0, -1, -1, 8'h00);
    frame(1, {CMD_RD_DATA, 8'h22}, 3, 0, -1, -1, 8'h5B);
    frame(1, {CMD_RD_ADDR, 8'h33}, 0, 0, -1, -1, 8'h00);
    frame(1, {CMD_RD_DATA, 8'h44}, 0, 0, -1, 3, 8'hE7);
    frame(1, {CMD_RD_ADDR, 8'h55}, 0, 0, -1, -1, 8'h00);
    rst_n = 0;
    tick();
    rst_n = 1;
    m_seen = 0;
    chk("rst_after_addr_seen", int'(dut.r_rd_addr_seen), 0);
    chk("rst_after_addr_rx_data", int'(rx_data), 0);
    tick();
    frame(1, {CMD_RD_ADDR, 8'h66}, 0, 0, -1, -1, 8'h00);
    frame(1, {CMD_RD_DATA, 8'h77}, 1, 0, -1, -1, 8'h81);
    for (int n = 0; n < 60; n++) begin
      int ab, ra;
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : -1;
      ra = (ab < 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
      frame(1'($urandom), 10'($urandom), int'($urandom_range(0, 4)), $urandom_range(0, 3) == 0, ab, ra, 8'($urandom));
    end
    repeat (3) tick();
    chk("rx_pending", rxq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
